// File: rtl/pll_clk_seq_ctrl_pkg.sv
// Shared definitions for the PLL bring-up / clock-gate sequencer:
// FSM state encodings, output widths and a width helper.
package pll_clk_seq_ctrl_pkg;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned RELOCK_W = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_STABLE    = 3'd3,
    ST_GATE_ON   = 3'd4,
    ST_READY     = 3'd5,
    ST_LOST      = 3'd6,
    ST_FAIL      = 3'd7
  } pll_state_e;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/pll_clk_seq_ctrl_lock_sync.sv
// Lock-flag synchroniser: SYNC_STAGES-deep flop chain bringing the
// asynchronous PLL lock into the clk domain.
//   clk     : destination clock
//   rst_n   : synchronous active-low reset, clears the chain to 0
//   async_i : asynchronous lock flag
//   sync_o  : synchronised lock flag
module pll_lock_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_clk_seq_ctrl.sv
// PLL bring-up / clock-gate sequencer. Holds the PLL in reset, qualifies the
// synchronised lock flag, opens the output clock gates one by one, watches
// for lock loss and retries a bounded number of times before failing.
//   clk, rst_n   : reference clock, synchronous active-low reset
//   en_i         : 1 = run sequence, 0 = park PLL in reset
//   pll_lock_i   : asynchronous PLL lock
//   pll_rst_o    : PLL reset (active high)
//   clk_gate_o   : per-output gate enables
//   ready_o      : all gates open with lock good
//   fail_o       : retries exhausted
//   lock_lost_o  : one-cycle pulse on lock loss
//   relock_cnt_o : saturating lock-loss count
//   state_o      : current FSM state
module pll_clk_seq_ctrl
  import pll_clk_seq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CLK        = 5,
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned GAP_CYCLES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic                pll_lock_i,
  output logic                pll_rst_o,
  output logic [NUM_CLK-1:0]  clk_gate_o,
  output logic                ready_o,
  output logic                fail_o,
  output logic                lock_lost_o,
  output logic [RELOCK_W-1:0] relock_cnt_o,
  output logic [STATE_W-1:0]  state_o
);

  localparam int unsigned CNT_W =
    $clog2(max4(RST_CYCLES, STABLE_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES)) + 1;
  localparam int unsigned IDX_W = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1;

  logic lock_s;

  pll_lock_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (pll_lock_i),
    .sync_o  (lock_s)
  );

  pll_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [3:0]          retry_q, retry_d;
  logic [RELOCK_W-1:0] relock_q, relock_d;
  logic [NUM_CLK-1:0]  gate_q, gate_d;
  logic                pll_rst_q, pll_rst_d;
  logic                ready_q, ready_d;
  logic                fail_q, fail_d;
  logic                lock_lost_q, lock_lost_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    retry_d  = retry_q;
    relock_d = relock_q;
    gate_d   = gate_q;

    unique case (state_q)
      ST_IDLE: begin
        if (en_i) begin
          state_d = ST_RESET;
          cnt_d   = CNT_W'(RST_CYCLES - 1);
        end
      end
      ST_RESET: begin
        if (cnt_q == '0) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = CNT_W'(TIMEOUT_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        // Lock seen on the final timeout cycle still wins over a retry.
        if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = CNT_W'(STABLE_CYCLES - 1);
        end else if (cnt_q == '0) begin
          retry_d = retry_q + 4'd1;
          if (retry_d == 4'(MAX_RETRY)) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_RESET;
            cnt_d   = CNT_W'(RST_CYCLES - 1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = CNT_W'(TIMEOUT_CYCLES - 1);
        end else if (cnt_q == '0) begin
          state_d = ST_GATE_ON;
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
          idx_d   = '0;
          gate_d  = NUM_CLK'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GATE_ON: begin
        if (!lock_s) begin
          state_d  = ST_LOST;
          retry_d  = '0;
          relock_d = (relock_q == '1) ? relock_q : relock_q + RELOCK_W'(1);
        end else if (cnt_q == '0) begin
          if (idx_q == IDX_W'(NUM_CLK - 1)) begin
            state_d = ST_READY;
          end else begin
            // Re-entering GATE_ON for the next bit reloads the gap counter.
            idx_d  = idx_q + IDX_W'(1);
            cnt_d  = CNT_W'(GAP_CYCLES - 1);
            gate_d = gate_q | (NUM_CLK'(1) << idx_d);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_READY: begin
        retry_d = '0;
        if (!lock_s) begin
          state_d  = ST_LOST;
          relock_d = (relock_q == '1) ? relock_q : relock_q + RELOCK_W'(1);
        end
      end
      ST_LOST: begin
        state_d = ST_RESET;
        cnt_d   = CNT_W'(RST_CYCLES - 1);
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
    endcase

    if (!en_i) begin
      state_d = ST_IDLE;
      retry_d = '0;
    end

    // Outputs are registered from the next state so they line up with state_o.
    if (!(state_d inside {ST_GATE_ON, ST_READY})) gate_d = '0;
    pll_rst_d   = state_d inside {ST_IDLE, ST_RESET, ST_FAIL};
    ready_d     = (state_d == ST_READY);
    fail_d      = (state_d == ST_FAIL);
    lock_lost_d = (state_d == ST_LOST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      retry_q     <= '0;
      relock_q    <= '0;
      gate_q      <= '0;
      pll_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      relock_q    <= relock_d;
      gate_q      <= gate_d;
      pll_rst_q   <= pll_rst_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign pll_rst_o    = pll_rst_q;
  assign clk_gate_o   = gate_q;
  assign ready_o      = ready_q;
  assign fail_o       = fail_q;
  assign lock_lost_o  = lock_lost_q;
  assign relock_cnt_o = relock_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_pll_clk_seq_ctrl.sv
// Bench for pll_clk_seq_ctrl. Expected behaviour is built from per-phase
// segment lengths (reset width, lock wait, qualification, gate gaps) and the
// two-cycle synchroniser latency of the lock input.
module tb_pll_clk_seq_ctrl;

  localparam int P_NUM = 3;
  localparam int P_RST = 4;
  localparam int P_STB = 8;
  localparam int P_GAP = 2;
  localparam int P_TO  = 20;
  localparam int P_MR  = 2;

  localparam int S_IDLE = 0, S_RESET = 1, S_WAIT = 2, S_STABLE = 3;
  localparam int S_GATE = 4, S_READY = 5, S_LOST = 6, S_FAIL = 7;

  logic       clk = 1'b0;
  logic       rst_n, en_i, pll_lock_i;
  logic       pll_rst_o, ready_o, fail_o, lock_lost_o;
  logic [2:0] clk_gate_o;
  logic [7:0] relock_cnt_o;
  logic [2:0] state_o;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic [7:0] exp_relock;

  pll_clk_seq_ctrl #(
    .NUM_CLK(P_NUM), .RST_CYCLES(P_RST), .STABLE_CYCLES(P_STB), .GAP_CYCLES(P_GAP),
    .TIMEOUT_CYCLES(P_TO), .MAX_RETRY(P_MR), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .pll_lock_i(pll_lock_i),
    .pll_rst_o(pll_rst_o), .clk_gate_o(clk_gate_o), .ready_o(ready_o),
    .fail_o(fail_o), .lock_lost_o(lock_lost_o), .relock_cnt_o(relock_cnt_o),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] expv(input int st, input int ng);
    logic prst;
    prst = (st == S_IDLE) || (st == S_RESET) || (st == S_FAIL);
    return {3'(st), prst, 3'((1 << ng) - 1), st == S_READY, st == S_FAIL,
            st == S_LOST, exp_relock};
  endfunction

  // Apply inputs for one clock, then check the registered outputs.
  task automatic step(input logic lk, input logic en, input int st, input int ng,
                      input string tag);
    logic [17:0] obs, exp;
    pll_lock_i = lk;
    en_i       = en;
    @(posedge clk);
    #1;
    cyc++;
    exp = expv(st, ng);
    obs = {state_o, pll_rst_o, clk_gate_o, ready_o, fail_o, lock_lost_o, relock_cnt_o};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d {st,rst,gate,rdy,fail,lost,relock} got=%h want=%h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic seg(input logic lk, input logic en, input int st, input int ng,
                     input int n, input string tag);
    for (int i = 0; i < n; i++) step(lk, en, st, ng, tag);
  endtask

  // Full bring-up: lock input rises d cycles into WAIT_LOCK; p>0 drops the
  // synchronised lock for one cycle after p qualification cycles.
  task automatic run_to_ready(input int d, input int p, input string tag);
    seg(1'b0, 1'b1, S_RESET, 0, P_RST, tag);
    seg(1'b0, 1'b1, S_WAIT, 0, d, tag);
    seg(1'b1, 1'b1, S_WAIT, 0, 2, tag);
    if (p > 0) begin
      for (int j = 0; j < p; j++) step((j == p - 2) ? 1'b0 : 1'b1, 1'b1, S_STABLE, 0, tag);
      step(1'b1, 1'b1, S_WAIT, 0, tag);
    end
    seg(1'b1, 1'b1, S_STABLE, 0, P_STB, tag);
    for (int g = 1; g <= P_NUM; g++) seg(1'b1, 1'b1, S_GATE, g, P_GAP, tag);
    step(1'b1, 1'b1, S_READY, P_NUM, tag);
  endtask

  task automatic lose_lock(input string tag);
    seg(1'b0, 1'b1, S_READY, P_NUM, 2, tag);
    if (exp_relock != 8'hff) exp_relock = exp_relock + 8'd1;
    step(1'b0, 1'b1, S_LOST, 0, tag);
  endtask

  task automatic timeout_cycle(input string tag);
    seg(1'b0, 1'b1, S_RESET, 0, P_RST, tag);
    seg(1'b0, 1'b1, S_WAIT, 0, P_TO, tag);
  endtask

  initial begin
    rst_n = 1'b0; en_i = 1'b0; pll_lock_i = 1'b0; exp_relock = 8'd0;
    seg(1'b0, 1'b0, S_IDLE, 0, 3, "reset");
    rst_n = 1'b1;
    seg(1'b0, 1'b0, S_IDLE, 0, 2, "idle");

    run_to_ready(5, 0, "nominal");
    seg(1'b1, 1'b1, S_READY, P_NUM, 3, "ready_hold");
    lose_lock("lost_in_ready");
    run_to_ready(int'($urandom_range(18, 0)), 5, "glitch_at_5");
    lose_lock("lost_again");
    run_to_ready(18, 7, "lock_last_wait_glitch_7");

    step(1'b0, 1'b0, S_IDLE, 0, "en_drop_ready");
    seg(1'b0, 1'b0, S_IDLE, 0, 2, "idle_park");

    // One timeout then success: READY and LOST must clear the retry count.
    timeout_cycle("retry_one");
    run_to_ready(int'($urandom_range(18, 0)), 0, "after_retry");
    lose_lock("lost_before_fail");
    for (int r = 0; r < P_MR; r++) timeout_cycle("retry_to_fail");
    seg(1'b0, 1'b1, S_FAIL, 0, 3, "fail_hold");
    step(1'b0, 1'b0, S_IDLE, 0, "fail_exit");

    for (int r = 0; r < P_MR; r++) timeout_cycle("no_lock");
    seg(1'b0, 1'b1, S_FAIL, 0, 2, "no_lock_fail");
    step(1'b0, 1'b0, S_IDLE, 0, "no_lock_exit");

    // en_i dropped with two gates open, then a reset pulse.
    seg(1'b0, 1'b1, S_RESET, 0, P_RST, "gate_drop");
    seg(1'b1, 1'b1, S_WAIT, 0, 2, "gate_drop");
    seg(1'b1, 1'b1, S_STABLE, 0, P_STB, "gate_drop");
    seg(1'b1, 1'b1, S_GATE, 1, P_GAP, "gate_drop");
    step(1'b1, 1'b1, S_GATE, 2, "gate_drop");
    step(1'b1, 1'b0, S_IDLE, 0, "en_drop_gate");
    seg(1'b0, 1'b0, S_IDLE, 0, 2, "idle_keep_relock");
    rst_n = 1'b0; exp_relock = 8'd0;
    seg(1'b0, 1'b0, S_IDLE, 0, 2, "rst_after_drop");
    rst_n = 1'b1;
    seg(1'b0, 1'b0, S_IDLE, 0, 2, "idle2");

    // Reset while waiting for lock.
    seg(1'b0, 1'b1, S_RESET, 0, P_RST, "rst_mid_wait");
    seg(1'b0, 1'b1, S_WAIT, 0, 3, "rst_mid_wait");
    rst_n = 1'b0;
    step(1'b0, 1'b1, S_IDLE, 0, "rst_mid_wait_chk");
    rst_n = 1'b1;
    step(1'b0, 1'b0, S_IDLE, 0, "idle3");

    // Many randomised loss events drive relock_cnt_o into saturation.
    for (int k = 0; k < 257; k++) begin
      run_to_ready(int'($urandom_range(18, 0)),
                   ($urandom_range(1, 0) == 1) ? int'($urandom_range(7, 2)) : 0, "sat_run");
      lose_lock("sat_lost");
    end
    run_to_ready(int'($urandom_range(18, 0)), 0, "sat_final");
    rst_n = 1'b0; exp_relock = 8'd0;
    step(1'b1, 1'b1, S_IDLE, 0, "rst_in_ready");
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
